// File: rtl/cacheline_burst_arbiter.sv
// cacheline_burst_arbiter: two-port (I-cache read, D-cache read/write) line arbiter that
//   serialises each BEATS*BEAT_W cache line into BEATS memory beats and back.
// Latency: 1 grant cycle + BEATS pmem_resp cycles + 1 DONE cycle (6 cycles at BEATS=4).
// Backpressure: requests are held until x_resp; pmem_resp paces the beats, and gaps simply
//   stall the beat counter. Only one line transaction is ever outstanding.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_read/i_address/i_rdata/i_resp   I-cache line read channel
//   d_read/d_write/d_address/d_wdata  D-cache line request (write wins if both asserted)
//   d_rdata/d_resp                    D-cache completion
//   pmem_*                            burst memory side; read/write/address are registered
// Optional: define ARB_PERF_CNT_EN to add the saturating perf_* counter outputs (CNT_W wide).
module cacheline_burst_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
`ifdef ARB_PERF_CNT_EN
  parameter int CNT_W  = 32,
`endif
  localparam int LINE_W = BEATS * BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_i_lines,
  output logic [CNT_W-1:0]  perf_d_rd_lines,
  output logic [CNT_W-1:0]  perf_d_wr_lines,
  output logic [CNT_W-1:0]  perf_conflict_cycles
`endif
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, last_grant_q;
  logic              write_q;
  logic [BW-1:0]     beat_q;
  logic [LINE_W-1:0] line_q;       // write line to send, or read line being assembled
  logic [LINE_W-1:0] line_merged;  // line_q with the current read beat folded in
  int unsigned       beat_base;

  logic d_req, i_req, any_req, grant_d, d_is_write, beat_last;

  // Byte-offset bits are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[OFF_W-1:0], d_address[OFF_W-1:0]};

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  assign i_req      = i_read;
  assign d_req      = d_read | d_write;
  assign any_req    = i_req | d_req;
  // Lone requester wins; on a tie, whoever did not get the previous grant goes.
  assign grant_d    = d_req & (~i_req | (last_grant_q == OWN_I));
  assign d_is_write = d_write;  // d_read && d_write resolves to a write
  assign beat_last  = (beat_q == BW'(BEATS - 1));

  always_comb begin
    beat_base = int'(beat_q) * BEAT_W;
  end

  always_comb begin
    line_merged = line_q;
    line_merged[beat_base +: BEAT_W] = pmem_rdata;
  end

  assign pmem_wdata = line_q[beat_base +: BEAT_W];

  // Next-state and completion outputs.
  always_comb begin
    state_d = state_q;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_XFER;
      end
      S_XFER: begin
        if (pmem_resp && beat_last) state_d = S_DONE;
      end
      S_DONE: begin
        i_resp  = (owner_q == OWN_I);
        d_resp  = (owner_q == OWN_D);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      write_q      <= 1'b0;
      beat_q       <= '0;
      line_q       <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q      <= grant_d ? OWN_D : OWN_I;
            last_grant_q <= grant_d ? OWN_D : OWN_I;
            write_q      <= grant_d & d_is_write;
            beat_q       <= '0;
            pmem_address <= line_align(grant_d ? d_address : i_address);
            line_q       <= (grant_d && d_is_write) ? d_wdata : '0;
            pmem_read    <= ~(grant_d & d_is_write);
            pmem_write   <= grant_d & d_is_write;
          end
        end
        S_XFER: begin
          if (pmem_resp) begin
            if (!write_q) line_q <= line_merged;
            if (beat_last) begin
              beat_q     <= '0;
              pmem_read  <= 1'b0;
              pmem_write <= 1'b0;
              // Publish the completed read line so it is stable for the DONE cycle.
              if (!write_q) begin
                if (owner_q == OWN_D) d_rdata <= line_merged;
                else                  i_rdata <= line_merged;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic i_served, d_served, conflict;

  // A requester counts as served when it is being granted now or already owns the port.
  always_comb begin
    i_served = 1'b0;
    d_served = 1'b0;
    if (state_q == S_IDLE) begin
      i_served = i_req & ~grant_d;
      d_served = grant_d;
    end else begin
      i_served = (owner_q == OWN_I);
      d_served = (owner_q == OWN_D);
    end
  end

  assign conflict = (i_req & ~i_served) | (d_req & ~d_served);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_lines         <= '0;
      perf_d_rd_lines      <= '0;
      perf_d_wr_lines      <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (state_q == S_DONE) begin
        if (owner_q == OWN_I) begin
          if (perf_i_lines != '1) perf_i_lines <= perf_i_lines + 1'b1;
        end else if (write_q) begin
          if (perf_d_wr_lines != '1) perf_d_wr_lines <= perf_d_wr_lines + 1'b1;
        end else begin
          if (perf_d_rd_lines != '1) perf_d_rd_lines <= perf_d_rd_lines + 1'b1;
        end
      end
      if (conflict && perf_conflict_cycles != '1)
        perf_conflict_cycles <= perf_conflict_cycles + 1'b1;
    end
  end
`endif

endmodule
